spi_slave_responder: RTL and testbench

- SPI slave-side responder: the receiving end of the bus whose chip selects the slave-select distributor drives.
- Oversamples SCLK, SS_n and MOSI in the system clock domain. Deserialises MOSI words and serialises a preloaded response word onto MISO.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- Used as the peer model on the chip-level bench and as the slave front end in the companion device.

---
 rtl/spi_slave_responder.sv | 115 +++++++++++
 tb/tb_spi_slave_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode 0 slave, oversampled in clk, rx deserialiser and tx holding register.
module spi_slave_responder #(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2;
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH), LAST = CW'(DATA_WIDTH - 1);
  logic sclk_m, sclk_s, sclk_d, ss_m, ss_n_s, mosi_m, mosi_s;
  logic [1:0] vld;
  logic armed;
  logic [1:0] state;
  logic [CW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift, tx_shift, hold;
  logic full, rise, fall, accept, done, quit, take;
  assign rise = sclk_s & ~sclk_d;
  assign fall = ~sclk_s & sclk_d;
  assign accept = tx_valid & ~full;
  assign done = state == SHIFT && bit_cnt == FULL;
  // a deselect coinciding with the final rising edge lets the word complete first
  assign quit = state == SHIFT && !done && ss_n_s && !(rise && bit_cnt == LAST);
  assign take = state == LOAD || (done && !ss_n_s);
  assign tx_ready = ~full;
  assign miso = miso_oe & tx_shift[DATA_WIDTH-1];
  // armed only after a genuinely sampled high ss_n, so a reset inside a frame waits for a fresh fall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {sclk_m, sclk_s, sclk_d} <= 3'b000;
      {ss_m, ss_n_s} <= 2'b11;
      {mosi_m, mosi_s} <= 2'b00;
      vld <= 2'b00;
      armed <= 1'b0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      ss_m <= ss_n;
      ss_n_s <= ss_m;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
      vld <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & ss_n_s);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full <= 1'b0;
      hold <= '0;
    end else if (accept) begin
      full <= 1'b1;
      hold <= tx_data;
    end else if (take) begin
      full <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      miso_oe <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= take & ~full;
      if (take) tx_shift <= full ? hold : IDLE_WORD;
      case (state)
        IDLE: if (armed && !ss_n_s) state <= LOAD;
        LOAD: begin
          bit_cnt <= '0;
          miso_oe <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (done) begin
          rx_data <= rx_shift;
          rx_valid <= 1'b1;
          bit_cnt <= '0;
          if (ss_n_s) begin
            state <= IDLE;
            miso_oe <= 1'b0;
          end
        end else if (quit) begin
          state <= IDLE;
          miso_oe <= 1'b0;
          frame_abort <= bit_cnt != '0;
          bit_cnt <= '0;
          rx_shift <= '0;
        end else if (rise) begin
          rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
          bit_cnt <= bit_cnt + 1'b1;
        end else if (fall && bit_cnt != '0) begin
          tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: SPI master model with a word-level reference for rx, miso and underrun counts.
module tb_spi_slave_responder;
  localparam int HALF = 80;
  logic clk = 0, rst_n = 0, sclk = 0, ss_n = 1, mosi = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort;
  logic [7:0] rx_data;
  int tests = 0, fails = 0;
  int n_rxv = 0, n_und = 0, n_abt = 0, und_mid = 0;
  logic [7:0] rx_log [256];
  logic [7:0] f_rx [3], f_tx [3], f_got [3];
  logic f_prov [3];
  logic oe_seen = 0;
  logic [7:0] last_rx = 0;

  spi_slave_responder dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[n_rxv[7:0]] <= rx_data;
      n_rxv <= n_rxv + 1;
    end
    if (tx_underrun) n_und <= n_und + 1;
    if (frame_abort) n_abt <= n_abt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic push_tx(input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    while (!tx_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL push_tx_ready: got %b want 1", tx_ready); end
    tx_data = d;
    tx_valid = 1;
    @(posedge clk);
    #1 tx_valid = 0;
  endtask

  task automatic send_word(input logic [7:0] d, input int nb, output logic [7:0] got);
    got = 0;
    for (int i = 0; i < nb; i++) begin
      mosi = d[7-i];
      #HALF sclk = 1;
      got = {got[6:0], miso};
      #HALF sclk = 0;
    end
  endtask

  task automatic run_frame(input int n);
    if (f_prov[0]) push_tx(f_tx[0]);
    ss_n = 0;
    #HALF oe_seen = miso_oe;
    for (int j = 0; j < n; j++) begin
      if (j + 1 < n && f_prov[j+1]) push_tx(f_tx[j+1]);
      if (j == n - 1) und_mid = n_und;
      send_word(f_rx[j], 8, f_got[j]);
    end
    #HALF ss_n = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests += 7;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", miso); end
    if (miso_oe !== 1'b0) begin fails++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
    if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    if (tx_underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b want 0", tx_underrun); end
    if (frame_abort !== 1'b0) begin fails++; $display("FAIL reset_abort: got %b want 0", frame_abort); end
    rst_n = 1;
    repeat (6) @(negedge clk);
    #2;
  endtask

  task automatic test_basic;
    int r0 = n_rxv, u0 = n_und, a0 = n_abt;
    f_rx[0] = 8'h3C; f_tx[0] = 8'hA5; f_prov[0] = 1;
    run_frame(1);
    tests += 7;
    if (n_rxv - r0 !== 1) begin fails++; $display("FAIL basic_rxv_count: got %0d want 1", n_rxv - r0); end
    if (rx_log[8'(r0)] !== 8'h3C) begin fails++; $display("FAIL basic_rx: got %h want 3c", rx_log[8'(r0)]); end
    if (f_got[0] !== 8'hA5) begin fails++; $display("FAIL basic_miso: got %h want a5", f_got[0]); end
    if (und_mid - u0 !== 0) begin fails++; $display("FAIL basic_underrun: got %0d want 0", und_mid - u0); end
    if (oe_seen !== 1'b1) begin fails++; $display("FAIL basic_oe_in_frame: got %b want 1", oe_seen); end
    if (miso_oe !== 1'b0) begin fails++; $display("FAIL basic_oe_after: got %b want 0", miso_oe); end
    if (n_abt - a0 !== 0) begin fails++; $display("FAIL basic_abort: got %0d want 0", n_abt - a0); end
    last_rx = 8'h3C;
  endtask

  task automatic test_back_to_back;
    int r0 = n_rxv, u0 = n_und;
    f_rx[0] = 8'h01; f_rx[1] = 8'h80; f_tx[0] = 8'h11; f_tx[1] = 8'h22;
    f_prov[0] = 1; f_prov[1] = 1;
    run_frame(2);
    tests += 6;
    if (n_rxv - r0 !== 2) begin fails++; $display("FAIL b2b_rxv_count: got %0d want 2", n_rxv - r0); end
    if (rx_log[8'(r0)] !== 8'h01) begin fails++; $display("FAIL b2b_rx0: got %h want 01", rx_log[8'(r0)]); end
    if (rx_log[8'(r0+1)] !== 8'h80) begin fails++; $display("FAIL b2b_rx1: got %h want 80", rx_log[8'(r0+1)]); end
    if (f_got[0] !== 8'h11) begin fails++; $display("FAIL b2b_miso0: got %h want 11", f_got[0]); end
    if (f_got[1] !== 8'h22) begin fails++; $display("FAIL b2b_miso1: got %h want 22", f_got[1]); end
    if (und_mid - u0 !== 0) begin fails++; $display("FAIL b2b_underrun: got %0d want 0", und_mid - u0); end
    last_rx = 8'h80;
  endtask

  task automatic test_underrun;
    int r0 = n_rxv, u0 = n_und;
    f_rx[0] = 8'hFF; f_prov[0] = 0;
    run_frame(1);
    tests += 4;
    if (und_mid - u0 !== 1) begin fails++; $display("FAIL und_at_load: got %0d want 1", und_mid - u0); end
    if (n_und - u0 !== 2) begin fails++; $display("FAIL und_total: got %0d want 2", n_und - u0); end
    if (f_got[0] !== 8'hFF) begin fails++; $display("FAIL und_miso: got %h want ff", f_got[0]); end
    if (rx_log[8'(r0)] !== 8'hFF) begin fails++; $display("FAIL und_rx: got %h want ff", rx_log[8'(r0)]); end
    last_rx = 8'hFF;
  endtask

  task automatic test_abort;
    int r0 = n_rxv, a0 = n_abt, u0 = n_und;
    logic [7:0] g;
    ss_n = 0;
    #HALF push_tx(8'h96);
    send_word(8'hB7, 5, g);
    #HALF ss_n = 1;
    repeat (8) @(negedge clk);
    tests += 7;
    if (n_abt - a0 !== 1) begin fails++; $display("FAIL abort_pulse: got %0d want 1", n_abt - a0); end
    if (n_rxv - r0 !== 0) begin fails++; $display("FAIL abort_rxv: got %0d want 0", n_rxv - r0); end
    if (rx_data !== last_rx) begin fails++; $display("FAIL abort_rx_kept: got %h want %h", rx_data, last_rx); end
    if (miso_oe !== 1'b0) begin fails++; $display("FAIL abort_oe: got %b want 0", miso_oe); end
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL abort_hold_kept: tx_ready %b want 0", tx_ready); end
    if (n_und - u0 !== 1) begin fails++; $display("FAIL abort_und: got %0d want 1", n_und - u0); end
    if (g[4:0] !== 5'h1F) begin fails++; $display("FAIL abort_miso: got %h want 1f", g[4:0]); end
    r0 = n_rxv; u0 = n_und;
    f_rx[0] = 8'h33; f_prov[0] = 0;
    run_frame(1);
    tests += 3;
    if (f_got[0] !== 8'h96) begin fails++; $display("FAIL abort_next_miso: got %h want 96", f_got[0]); end
    if (und_mid - u0 !== 0) begin fails++; $display("FAIL abort_next_und: got %0d want 0", und_mid - u0); end
    if (rx_log[8'(r0)] !== 8'h33) begin fails++; $display("FAIL abort_next_rx: got %h want 33", rx_log[8'(r0)]); end
    last_rx = 8'h33;
  endtask

  task automatic test_reset_midframe;
    int r0;
    logic [7:0] g, t;
    ss_n = 0;
    #HALF send_word(8'hC3, 3, g);
    mosi = 0;
    #(HALF/2) rst_n = 0;
    #1;
    tests += 5;
    if (miso_oe !== 1'b0) begin fails++; $display("FAIL mrst_oe: got %b want 0", miso_oe); end
    if (miso !== 1'b0) begin fails++; $display("FAIL mrst_miso: got %b want 0", miso); end
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL mrst_tx_ready: got %b want 1", tx_ready); end
    if (rx_data !== 8'h00) begin fails++; $display("FAIL mrst_rx_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin fails++; $display("FAIL mrst_rx_valid: got %b want 0", rx_valid); end
    #20 rst_n = 1;
    r0 = n_rxv;
    send_word(8'hFF, 8, g);
    tests += 2;
    if (miso_oe !== 1'b0) begin fails++; $display("FAIL mrst_no_restart_oe: got %b want 0", miso_oe); end
    if (n_rxv - r0 !== 0) begin fails++; $display("FAIL mrst_no_restart_rxv: got %0d want 0", n_rxv - r0); end
    ss_n = 1;
    repeat (8) @(negedge clk);
    r0 = n_rxv;
    t = 8'($urandom);
    f_rx[0] = 8'h5A; f_tx[0] = t; f_prov[0] = 1;
    run_frame(1);
    tests += 2;
    if (rx_log[8'(r0)] !== 8'h5A) begin fails++; $display("FAIL mrst_rx: got %h want 5a", rx_log[8'(r0)]); end
    if (f_got[0] !== t) begin fails++; $display("FAIL mrst_miso: got %h want %h", f_got[0], t); end
    last_rx = 8'h5A;
  endtask

  task automatic test_idle_sclk;
    int r0 = n_rxv, bad = 0;
    for (int i = 0; i < 12; i++) begin
      mosi = 1'($urandom);
      #HALF sclk = 1;
      if (miso_oe !== 1'b0) bad++;
      #HALF sclk = 0;
    end
    repeat (8) @(negedge clk);
    tests += 3;
    if (n_rxv - r0 !== 0) begin fails++; $display("FAIL idle_rxv: got %0d want 0", n_rxv - r0); end
    if (bad !== 0) begin fails++; $display("FAIL idle_oe: %0d samples high want 0", bad); end
    if (dut.bit_cnt !== '0) begin fails++; $display("FAIL idle_bit_cnt: got %0d want 0", dut.bit_cnt); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 12; it++) begin
      int n, miss, r0, u0, a0;
      logic [7:0] e;
      n = $urandom_range(1, 3);
      miss = 0;
      r0 = n_rxv; u0 = n_und; a0 = n_abt;
      for (int j = 0; j < 3; j++) begin
        f_rx[j] = 8'($urandom);
        f_tx[j] = 8'($urandom);
        f_prov[j] = 1'($urandom);
        if (j < n && !f_prov[j]) miss++;
      end
      run_frame(n);
      tests += 5;
      if (n_rxv - r0 !== n) begin fails++; $display("FAIL rnd_rxv_count: got %0d want %0d", n_rxv - r0, n); end
      if (und_mid - u0 !== miss) begin fails++; $display("FAIL rnd_und_mid: got %0d want %0d", und_mid - u0, miss); end
      if (n_und - u0 !== miss + 1) begin fails++; $display("FAIL rnd_und_total: got %0d want %0d", n_und - u0, miss + 1); end
      if (miso_oe !== 1'b0) begin fails++; $display("FAIL rnd_oe_after: got %b want 0", miso_oe); end
      if (n_abt - a0 !== 0) begin fails++; $display("FAIL rnd_abort: got %0d want 0", n_abt - a0); end
      for (int j = 0; j < n; j++) begin
        e = f_prov[j] ? f_tx[j] : 8'hFF;
        tests += 2;
        if (rx_log[8'(r0+j)] !== f_rx[j]) begin fails++; $display("FAIL rnd_rx[%0d]: got %h want %h", j, rx_log[8'(r0+j)], f_rx[j]); end
        if (f_got[j] !== e) begin fails++; $display("FAIL rnd_miso[%0d]: got %h want %h", j, f_got[j], e); end
      end
      last_rx = f_rx[n-1];
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_underrun;
    test_abort;
    test_reset_midframe;
    test_idle_sclk;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
